// File: rtl/usb_rx_ctrl_gen2.sv
// USB receive control FSM: SYNC check, PID capture, data-byte FIFO writes and byte counting.
// Optional bit-period inactivity timeout is enabled by defining RCU_TIMEOUT_EN.
module usb_rx_ctrl_gen2 #(
    parameter logic [7:0] SYNC_BYTE    = 8'h80,
    parameter int         MAX_BYTES    = 64,
    parameter int         TIMEOUT_BITS = 16,
    localparam int        CNT_W        = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic [7:0]       rcv_data,
    input  logic             byte_received,
    input  logic             PID_err,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic             PID_clear,
    output logic             PID_set,
    output logic [CNT_W-1:0] byte_count,
    output logic             pkt_done,
    output logic [2:0]       err_code
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] SYNC      = 4'd1;
    localparam logic [3:0] PID_WAIT  = 4'd2;
    localparam logic [3:0] PID_RCV   = 4'd3;
    localparam logic [3:0] PID_WRITE = 4'd4;
    localparam logic [3:0] PID_CHECK = 4'd5;
    localparam logic [3:0] WAIT      = 4'd6;
    localparam logic [3:0] RCV       = 4'd7;
    localparam logic [3:0] WRITE     = 4'd8;
    localparam logic [3:0] EOP       = 4'd9;
    localparam logic [3:0] ERR       = 4'd10;
    localparam logic [3:0] EEOP      = 4'd11;
    localparam logic [3:0] EIDLE     = 4'd12;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    logic [3:0] state, next_state;
    logic [2:0] cause;
    logic       to_hit;
    logic       se_eop;

    assign se_eop = shift_enable & eop;

`ifdef RCU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
    logic [TO_W-1:0] to_cnt;
    logic            in_data_phase;

    assign in_data_phase = (state == WAIT) || (state == RCV);
    // The TIMEOUT_BITS-th idle bit period fires the error; eop/byte_received that cycle win.
    assign to_hit = in_data_phase && shift_enable && !eop && !byte_received
                    && (to_cnt == TO_W'(TIMEOUT_BITS - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt <= '0;
        end else if (!in_data_phase || byte_received) begin
            to_cnt <= '0;
        end else if (shift_enable) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_BITS > 0);
    assign to_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        next_state = state;
        cause      = 3'd0;
        case (state)
            IDLE, EIDLE: if (d_edge) next_state = SYNC;
            SYNC: begin
                if (byte_received) begin
                    if (rcv_data == SYNC_BYTE) begin
                        next_state = PID_WAIT;
                    end else begin
                        next_state = ERR;
                        cause      = 3'd1;
                    end
                end
            end
            PID_WAIT: begin
                if (se_eop) begin
                    next_state = EEOP;
                    cause      = 3'd3;
                end else if (shift_enable) begin
                    next_state = PID_RCV;
                end
            end
            PID_RCV: begin
                if (se_eop) begin
                    next_state = EEOP;
                    cause      = 3'd3;
                end else if (byte_received) begin
                    next_state = PID_WRITE;
                end
            end
            PID_WRITE: next_state = PID_CHECK;
            PID_CHECK: begin
                if (PID_err) begin
                    next_state = ERR;
                    cause      = 3'd2;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (se_eop) begin
                    next_state = EOP;
                end else if (to_hit) begin
                    next_state = ERR;
                    cause      = 3'd5;
                end else if (shift_enable) begin
                    next_state = RCV;
                end
            end
            RCV: begin
                if (byte_received) begin
                    if (byte_count < MAX_CNT) begin
                        next_state = WRITE;
                    end else begin
                        next_state = ERR;
                        cause      = 3'd4;
                    end
                end else if (se_eop) begin
                    next_state = EEOP;
                    cause      = 3'd3;
                end else if (to_hit) begin
                    next_state = ERR;
                    cause      = 3'd5;
                end
            end
            WRITE:   next_state = WAIT;
            EOP:     if (d_edge) next_state = IDLE;
            ERR:     if (se_eop) next_state = EEOP;
            EEOP:    if (d_edge) next_state = EIDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            byte_count <= '0;
            err_code   <= 3'd0;
            pkt_done   <= 1'b0;
        end else begin
            state    <= next_state;
            pkt_done <= (next_state == EOP) && (state != EOP);
            if ((next_state == SYNC) && (state != SYNC)) begin
                byte_count <= '0;
                err_code   <= 3'd0;
            end else begin
                if ((state == WRITE) && (byte_count < MAX_CNT)) begin
                    byte_count <= byte_count + CNT_W'(1);
                end
                // First cause wins: ERR -> EEOP keeps the code already recorded.
                if (((next_state == ERR) || (next_state == EEOP)) &&
                    (state != ERR) && (state != EEOP)) begin
                    err_code <= cause;
                end
            end
        end
    end

    always_comb begin
        rcving    = 1'b1;
        w_enable  = 1'b0;
        r_error   = 1'b0;
        PID_clear = 1'b0;
        PID_set   = 1'b0;
        case (state)
            IDLE:      rcving = 1'b0;
            SYNC:      PID_clear = 1'b1;
            PID_WRITE: PID_set = 1'b1;
            WRITE:     w_enable = 1'b1;
            ERR, EEOP: r_error = 1'b1;
            EIDLE: begin
                rcving  = 1'b0;
                r_error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
